// File: rtl/shift_add_mul_16bit_pkg.sv
// Shared types and sizes for the shift-and-add multiplier.
package mul_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} mul_state_t;

endpackage

// File: rtl/shift_add_mul_16bit_if.sv
// Operand/product handshake bundle: master supplies operands and takes the product.
interface shift_add_mul_16bit_if;

    logic                           in_valid;
    logic                           in_ready;
    logic [mul_pkg::WIDTH-1:0]      a;
    logic [mul_pkg::WIDTH-1:0]      b;
    logic                           out_valid;
    logic                           out_ready;
    logic [2*mul_pkg::WIDTH-1:0]    product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/prefix_adder_16bit.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module prefix_adder_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [15:0] prop;
    logic [15:0] gen;
    logic [15:0] grp_p;
    logic [15:0] gen_n;
    logic [15:0] prop_n;

    always_comb begin
        prop   = A ^ B;
        gen    = A & B;
        // Fold carry-in into bit 0 so every group generate is a true carry.
        gen[0] = gen[0] | (prop[0] & Cin);
        grp_p  = prop;
        gen_n  = '0;
        prop_n = '0;
        for (int l = 0; l < 4; l++) begin
            gen_n  = gen;
            prop_n = grp_p;
            for (int i = (1 << l); i < 16; i++) begin
                gen_n[i]  = gen[i] | (grp_p[i] & gen[i - (1 << l)]);
                prop_n[i] = grp_p[i] & grp_p[i - (1 << l)];
            end
            gen   = gen_n;
            grp_p = prop_n;
        end
        S    = prop ^ {gen[14:0], Cin};
        Cout = gen[15];
    end

endmodule

// File: rtl/shift_add_mul_16bit.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier, one step per clock.
// Define MUL_EARLY_TERM_EN to finish early once the remaining multiplier bits are zero.
module shift_add_mul_16bit
    import mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    shift_add_mul_16bit_if.slave  bus
);

    mul_state_t         state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;

    assign addend = lo_q[0] ? mcand_q : '0;

    prefix_adder_16bit u_adder (
        .A    (hi_q),
        .B    (addend),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (carry)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = bus.a;
                    hi_d    = '0;
                    lo_d    = bus.b;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
`ifdef MUL_EARLY_TERM_EN
                // lo[15-cnt:0] are the multiplier bits not yet consumed.
                if ((lo_q & (16'hFFFF >> cnt_q)) == '0) begin
                    {hi_d, lo_d} = {hi_q, lo_q} >> (5'd16 - {1'b0, cnt_q});
                    state_d      = HOLD;
                end else
`endif
                begin
                    {hi_d, lo_d} = {carry, sum, lo_q[WIDTH-1:1]};
                    cnt_d        = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == HOLD);
        bus.product   = {hi_q, lo_q};
    end

endmodule

// File: tb/tb_shift_add_mul_16bit.sv
// Self-checking bench for shift_add_mul_16bit: per-cycle model compare plus directed/random transactions.
module tb_shift_add_mul_16bit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_add_mul_16bit_if bus ();

    shift_add_mul_16bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef MUL_EARLY_TERM_EN
    localparam int LatMul35  = 4;
    localparam int LatZero   = 1;
    localparam int Lat0101   = 10;
`else
    localparam int LatMul35  = 16;
    localparam int LatZero   = 16;
    localparam int Lat0101   = 16;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Number of clock edges spent computing after the accept edge.
    function automatic int ref_lat(input logic [15:0] b);
`ifdef MUL_EARLY_TERM_EN
        int m;
        if (b == 16'h0) return 1;
        m = 0;
        for (int i = 0; i < 16; i++) if (b[i]) m = i;
        return (m + 2 > 16) ? 16 : m + 2;
`else
        return 16;
`endif
    endfunction

    // Transaction-level model: idle, busy for ref_lat edges, then holding a*b.
    typedef enum {MIdle, MBusy, MHold} phase_t;
    phase_t      ph     = MIdle;
    int          remain = 0;
    logic [31:0] m_prod = '0;
    bit          fresh  = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph     <= MIdle;
            m_prod <= '0;
            fresh  <= 1'b1;
        end else begin
            case (ph)
                MIdle: if (bus.in_valid) begin
                    ph     <= MBusy;
                    remain <= ref_lat(bus.b);
                    m_prod <= 32'(bus.a) * 32'(bus.b);
                    fresh  <= 1'b0;
                end
                MBusy: begin
                    if (remain == 1) ph <= MHold;
                    else remain <= remain - 1;
                end
                MHold: if (bus.out_ready) ph <= MIdle;
                default: ph <= MIdle;
            endcase
        end
    end

    always @(negedge clk) begin
        check("in_ready", 32'(bus.in_ready), 32'(ph == MIdle));
        check("out_valid", 32'(bus.out_valid), 32'(ph == MHold));
        if (ph == MHold) check("product", bus.product, m_prod);
        else if (ph == MIdle && fresh) check("product_reset", bus.product, 32'h0);
    end

    task automatic txn(input logic [15:0] a, input logic [15:0] b, input int stall,
                       output logic [31:0] got, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = (stall == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        got = '0;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid || lat >= 40) break;
        end
        if (!bus.out_valid) begin
            check("timeout_out_valid", 32'(bus.out_valid), 32'h1);
            bus.out_ready = 1'b1;
            return;
        end
        got = bus.product;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = i[0];
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            @(negedge clk);
            check("hold_in_ready", 32'(bus.in_ready), 32'h0);
            check("hold_out_valid", 32'(bus.out_valid), 32'h1);
            check("hold_product", bus.product, got);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_after", 32'(bus.in_ready), 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          lat;
        logic [15:0] ra, rb;
        int          stall;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'h1);
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_product", bus.product, 32'h0);

        txn(16'h1234, 16'h5678, 0, got, lat);
        check("p_1234_5678", got, 32'h06260060);
        check("lat_1234_5678", 32'(lat), 32'd16);

        txn(16'hFFFF, 16'hFFFF, 0, got, lat);
        check("p_ffff_ffff", got, 32'hFFFE0001);
        check("lat_ffff_ffff", 32'(lat), 32'd16);

        txn(16'h0003, 16'h0005, 0, got, lat);
        check("p_3_5", got, 32'h0000000F);
        check("lat_3_5", 32'(lat), 32'(LatMul35));

        txn(16'hABCD, 16'h0000, 0, got, lat);
        check("p_abcd_0", got, 32'h0);
        check("lat_abcd_0", 32'(lat), 32'(LatZero));

        // Stall in HOLD for 5 cycles with ignored in_valid pulses.
        txn(16'h1234, 16'h5678, 5, got, lat);
        check("p_stall", got, 32'h06260060);

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 16'h1234;
        bus.b         = 16'h5678;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("async_rst_product", bus.product, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        txn(16'h00FF, 16'h0101, 0, got, lat);
        check("p_00ff_0101", got, 32'h0000FFFF);
        check("lat_00ff_0101", 32'(lat), 32'(Lat0101));

        for (int n = 0; n < 200; n++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom) & (16'hFFFF >> $urandom_range(0, 16));
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            txn(ra, rb, stall, got, lat);
            check("rand_product", got, 32'(ra) * 32'(rb));
            check("rand_latency", 32'(lat), 32'(ref_lat(rb)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
